// File: rtl/out_port_seg_driver_if.sv
// Port bundle for the seven-segment output-port driver.
// Value/mode inputs plus registered display and status outputs.
interface out_port_seg_driver_if;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output out_port0, out_port1,
        input  hex0, hex1, hex2, hex3, hex4, hex5,
        input  busy, done, ovf
    );

    modport slave (
        input  out_port0, out_port1,
        output hex0, hex1, hex2, hex3, hex4, hex5,
        output busy, done, ovf
    );
endinterface

// File: rtl/out_port_seg_driver.sv
// Six-digit seven-segment driver for a memory-mapped output port.
// Decimal via serial double-dabble, or direct hex, with leading-zero blanking.
module out_port_seg_driver (
    input  logic               io_clk,
    input  logic               clm,
    out_port_seg_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] last_val;
    logic [1:0]  last_mode;
    logic [19:0] opnd;
    logic [23:0] bcd;
    logic [4:0]  cnt;
    logic        ovf_w;
    logic        changed;
    logic [31:0] dec_in;
    logic [23:0] bcd_adj;
    logic [5:0]  blank;
    logic        lead;
    logic [5:0][6:0] seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        changed = (bus.out_port0 != last_val) ||
                  (bus.out_port1[1:0] != last_mode);
        dec_in  = (bus.out_port0 > 32'd999999) ? 32'd999999
                                               : bus.out_port0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (changed)
                    state_nx = bus.out_port1[0] ? UPDATE : CONV;
            CONV:
                if (cnt == 5'd19)
                    state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge io_clk) begin
        if (!clm) state <= IDLE;
        else      state <= state_nx;
    end

    // Add-3 correction applied to every digit before each shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 6; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Blank each digit whose position and everything above it is zero
    always_comb begin
        blank = '0;
        lead  = last_mode[1];
        for (int k = 5; k >= 1; k--) begin
            lead     = lead && (bcd[4*k +: 4] == 4'd0);
            blank[k] = lead;
        end
        for (int k = 0; k < 6; k++) begin
            seg_nx[k] = blank[k] ? 7'h7F : seg7(bcd[4*k +: 4]);
        end
    end

    always_ff @(posedge io_clk) begin
        if (!clm) begin
            last_val  <= '0;
            last_mode <= '0;
            opnd      <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ovf_w     <= 1'b0;
            bus.hex0  <= 7'h40;
            bus.hex1  <= 7'h40;
            bus.hex2  <= 7'h40;
            bus.hex3  <= 7'h40;
            bus.hex4  <= 7'h40;
            bus.hex5  <= 7'h40;
            bus.ovf   <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= (state == UPDATE);
            case (state)
                IDLE:
                    if (changed) begin
                        last_val  <= bus.out_port0;
                        last_mode <= bus.out_port1[1:0];
                        cnt       <= '0;
                        if (bus.out_port1[0]) begin
                            bcd   <= bus.out_port0[23:0];
                            opnd  <= '0;
                            ovf_w <= |bus.out_port0[31:24];
                        end else begin
                            bcd   <= '0;
                            opnd  <= dec_in[19:0];
                            ovf_w <= (bus.out_port0 > 32'd999999);
                        end
                    end
                CONV: begin
                    {bcd, opnd} <= {bcd_adj, opnd} << 1;
                    cnt         <= cnt + 5'd1;
                end
                UPDATE: begin
                    bus.hex0 <= seg_nx[0];
                    bus.hex1 <= seg_nx[1];
                    bus.hex2 <= seg_nx[2];
                    bus.hex3 <= seg_nx[3];
                    bus.hex4 <= seg_nx[4];
                    bus.hex5 <= seg_nx[5];
                    bus.ovf  <= ovf_w;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_out_port_seg_driver.sv
// Directed bench for the seven-segment output-port driver.
// Expected segment codes are hand-computed from the digit table.
module tb_out_port_seg_driver;
    logic io_clk;
    logic clm;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   bz;
    logic [41:0] hx;

    out_port_seg_driver_if bus ();

    out_port_seg_driver dut (
        .io_clk (io_clk),
        .clm    (clm),
        .bus    (bus.slave)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    assign hx = {bus.hex5, bus.hex4, bus.hex3,
                 bus.hex2, bus.hex1, bus.hex0};

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] v, input logic [31:0] m);
        @(negedge io_clk);
        bus.out_port0 = v;
        bus.out_port1 = m;
    endtask

    // Counts sampled cycles and busy cycles up to and including done
    task automatic wait_done(output int c, output int b);
        bit seen;
        c    = 0;
        b    = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge io_clk);
            c++;
            if (bus.busy) b++;
            if (bus.done) seen = 1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clm   = 1'b0;
        bus.out_port0 = '0;
        bus.out_port1 = '0;
        repeat (2) @(negedge io_clk);
        check("rst_hex",  hx, {6{7'h40}});
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ovf",  bus.ovf, 0);
        clm = 1'b1;
        repeat (5) begin
            @(negedge io_clk);
            check("zero_idle_busy", bus.busy, 0);
            check("zero_idle_done", bus.done, 0);
        end

        apply(32'd123456, 32'd0);
        wait_done(cyc, bz);
        check("dec_latency", cyc, 22);
        check("dec_busy",    bz, 21);
        check("dec_hex", hx, {7'h79, 7'h24, 7'h30,
                              7'h19, 7'h12, 7'h02});
        check("dec_ovf", bus.ovf, 0);
        @(negedge io_clk);
        check("dec_done_pulse", bus.done, 0);

        apply(32'hFFFF_FFFF, 32'd0);
        wait_done(cyc, bz);
        check("sat_latency", cyc, 22);
        check("sat_hex", hx, {6{7'h10}});
        check("sat_ovf", bus.ovf, 1);

        apply(32'h0100_00AF, 32'd3);
        wait_done(cyc, bz);
        check("hexm_latency", cyc, 2);
        check("hexm_busy",    bz, 1);
        check("hexm_hex", hx, {7'h7F, 7'h7F, 7'h7F,
                               7'h7F, 7'h08, 7'h0E});
        check("hexm_ovf", bus.ovf, 1);

        apply(32'd555555, 32'd0);
        repeat (3) @(negedge io_clk);
        check("pre_rst_busy", bus.busy, 1);
        clm = 1'b0;
        bus.out_port0 = '0;
        bus.out_port1 = '0;
        @(negedge io_clk);
        check("mid_rst_hex",  hx, {6{7'h40}});
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_ovf",  bus.ovf, 0);
        clm = 1'b1;
        repeat (30) begin
            @(negedge io_clk);
            check("post_rst_done", bus.done, 0);
            check("post_rst_busy", bus.busy, 0);
        end

        apply(32'd9, 32'd0);
        wait_done(cyc, bz);
        check("nine_latency", cyc, 22);
        check("nine_hex", hx, {{5{7'h40}}, 7'h10});

        apply(32'd1234, 32'd2);
        wait_done(cyc, bz);
        check("declz_latency", cyc, 22);
        check("declz_hex", hx, {7'h7F, 7'h7F, 7'h79,
                                7'h24, 7'h30, 7'h19});

        apply(32'd0, 32'd3);
        wait_done(cyc, bz);
        check("zlz_latency", cyc, 2);
        check("zlz_hex", hx, {{5{7'h7F}}, 7'h40});
        check("zlz_ovf", bus.ovf, 0);

        apply(32'd42, 32'd0);
        repeat (5) @(negedge io_clk);
        bus.out_port0 = 32'd7;
        wait_done(cyc, bz);
        check("mid1_latency", cyc, 17);
        check("mid1_hex", hx, {{4{7'h40}}, 7'h19, 7'h24});
        @(negedge io_clk);
        check("mid_recapture_busy", bus.busy, 1);
        check("mid_recapture_done", bus.done, 0);
        wait_done(cyc, bz);
        check("mid2_latency", cyc, 21);
        check("mid2_hex", hx, {{5{7'h40}}, 7'h78});
        check("mid2_ovf", bus.ovf, 0);

        repeat (100) begin
            @(negedge io_clk);
            check("hold_busy", bus.busy, 0);
            check("hold_done", bus.done, 0);
            check("hold_hex",  hx, {{5{7'h40}}, 7'h78});
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/out_port_seg_driver.md
OUT_PORT_SEG_DRIVER -- requirements
Module: out_port_seg_driver

Interface
REQ-001 The block SHALL expose these ports, one per line:
- io_clk  in  1  sole clock; all state updates on the rising edge.
- clm  in  1  reset; synchronous and active-low.
- out_port0  in  32  value to display, unsigned.
- out_port1  in  32  mode word; only bit0 (hex_mode) and bit1 (blank_lz) are used, bits 31:2 are ignored.
- hex0..hex5  out  7 each  seven-segment codes, active-low, bit0=a .. bit6=g; hex0 is the least significant digit.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the display outputs have just been updated.
- ovf  out  1  the displayed value is saturated or truncated.

REQ-002 The block SHALL have no parameters; all widths are fixed as listed above.

Function
REQ-003 The block SHALL keep shadow registers last_val[31:0] and last_mode[1:0].
REQ-004 The FSM SHALL have three states: IDLE, CONV and UPDATE.
REQ-005 In IDLE, at edge E, the block SHALL capture the inputs if out_port0 != last_val or out_port1[1:0] != last_mode.
- The capture loads last_val, last_mode and the working registers.
- Next state is CONV if hex_mode=0, else UPDATE.
REQ-006 In IDLE with no difference, the block SHALL stay in IDLE and leave all outputs unchanged.

REQ-007 Decimal capture SHALL compute the operand as min(out_port0, 999999).
- The operand is loaded into a 20-bit shift register.
- The BCD accumulator (24 bits, 6 digits) is cleared.
- ovf_next = (out_port0 > 999999).
REQ-008 CONV SHALL perform one double-dabble iteration per edge, 20 iterations at edges E+1..E+20.
- Each iteration first adds 3 to every BCD digit >= 5, then shifts {bcd, operand} left by one bit.
- A 5-bit counter runs from 0 to 19; after the 20th iteration the next state is UPDATE.
REQ-009 Hex capture SHALL take digits from out_port0[23:0], nibble k driving hex k.
- ovf_next = |out_port0[31:24].
REQ-010 In UPDATE, the block SHALL register hex0..hex5 and ovf from the working registers.
- It SHALL assert done for exactly the following cycle and return to IDLE.
- Latency: the edge at which the outputs update is E+21 in decimal mode and E+1 in hex mode.
REQ-011 busy SHALL be 1 in CONV and UPDATE, and 0 in IDLE.
REQ-012 Input changes during CONV or UPDATE SHALL NOT affect the conversion in progress.
- They are detected on the first IDLE cycle afterwards and start a new conversion; no update is lost or merged.
- Back-to-back conversions therefore have one IDLE cycle between UPDATE and the next capture.

REQ-013 The segment encoding SHALL be the following 7-bit codes (hex):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- blank = 7F.
REQ-014 When blank_lz=1, every digit above the most significant nonzero digit SHALL show 7F; hex0 is never blanked, so the value 0 shows "0".
- This rule applies in both decimal and hex modes.
REQ-015 Digit codes and blanking SHALL be computed from the working registers and registered only in UPDATE, so hex outputs never show partial conversion results.

Reset
REQ-016 When clm=0 at a rising edge, the block SHALL, on that edge and in any state:
- go to IDLE, abandoning any conversion in progress;
- clear last_val, last_mode, the counter, the BCD accumulator and the operand to 0;
- set hex0..hex5 = 40, showing "000000";
- clear busy, done and ovf to 0.
REQ-017 Reset SHALL have priority over every other action.
- After reset is released, an out_port0 of 0 with mode 0 causes no conversion.
- Any nonzero value, or any nonzero mode, causes a conversion on the first edge with clm=1.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Decimal: reset, then out_port0=123456 and out_port1=0 -> busy for 21 cycles; at E+21, hex5..hex0 = 79,24,30,19,12,02; done pulses once; ovf=0.
- Saturation: out_port0=32'hFFFFFFFF with decimal mode -> all digits 10 ("999999"); ovf=1.
- Hex with blanking: out_port0=32'h0100_00AF and out_port1=3 -> at E+1, hex0=0E, hex1=08, hex5..hex2=7F; ovf=1.
- Mid-conversion change: out_port0=42, then 7 applied 5 cycles after capture -> the display first shows 42 with done; one IDLE cycle later a second capture occurs; the display then shows 7 with a second done.
- Reset mid-conversion: clm=0 during CONV -> next cycle all hex=40, busy=0, done=0; no done pulse follows.
- No-change idle: hold the inputs constant for 100 cycles after an update -> busy=0, done=0 and hex stable throughout.
